// File: rtl/move_cmd_arbiter.sv
// move_cmd_arbiter: merges up/down movement requests from the board push buttons and the
// PS2 arrow-key flags into a single paced move-strobe stream for the pixel generator.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing samples before a button level flips
//   HOLD_FRAMES      frame ticks from the first strobe to the first repeat strobe (>= 1)
//   REPEAT_FRAMES    frame ticks between repeat strobes (>= 1)
//   KB_PRIORITY      1: keyboard wins a simultaneous request from idle, 0: buttons win
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   btn_up      raw push button (asynchronous)
//   btn_down    raw push button (asynchronous)
//   kb_up       PS2 up-arrow held flag (asynchronous level)
//   kb_down     PS2 down-arrow held flag (asynchronous level)
//   frame_tick  one-cycle pulse per video frame
//   move_up     one-cycle strobe, move paddle up
//   move_down   one-cycle strobe, move paddle down
//   owner       00 none, 01 buttons, 10 keyboard
module move_cmd_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_FRAMES     = 15,
  parameter int unsigned REPEAT_FRAMES   = 2,
  parameter bit          KB_PRIORITY     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       kb_up,
  input  logic       kb_down,
  input  logic       frame_tick,
  output logic       move_up,
  output logic       move_down,
  output logic [1:0] owner
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned WMAX   = (HOLD_FRAMES > REPEAT_FRAMES) ? HOLD_FRAMES : REPEAT_FRAMES;
  localparam int unsigned WCNT_W = $clog2(WMAX) + 1;

  // The counter value at which the next disagreeing sample is the DEBOUNCE_CYCLES-th one.
  localparam logic [CNT_W-1:0]  DbLast     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WCNT_W-1:0] HoldLoad   = WCNT_W'(HOLD_FRAMES - 1);
  localparam logic [WCNT_W-1:0] RepeatLoad = WCNT_W'(REPEAT_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBtn  = 2'b01,
    StKb   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    DirNone = 2'b00,
    DirUp   = 2'b01,
    DirDown = 2'b10
  } dir_e;

  function automatic dir_e decode_dir(input logic up, input logic down);
    if (up && !down) begin
      return DirUp;
    end else if (down && !up) begin
      return DirDown;
    end else begin
      return DirNone;
    end
  endfunction

  // Bit order: {kb_down, kb_up, btn_down, btn_up}
  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q;

  logic [1:0]       btn_lvl_q, btn_lvl_d;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              first_q, first_d;
  logic              move_up_q, move_up_d;
  logic              move_down_q, move_down_d;

  dir_e              btn_dir, kb_dir, own_dir;
  logic              btn_act, kb_act, own_act;
  logic [WCNT_W-1:0] wcnt_cur;
  logic              first_cur;

  assign raw = {kb_down, kb_up, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive samples that disagree with the current level; any agreeing
  // sample restarts the count.
  always_comb begin
    btn_lvl_d = btn_lvl_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != btn_lvl_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          btn_lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_lvl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      btn_lvl_q <= btn_lvl_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign btn_dir = decode_dir(btn_lvl_q[0], btn_lvl_q[1]);
  assign kb_dir  = decode_dir(sync2_q[2], sync2_q[3]);
  assign btn_act = btn_lvl_q[0] | btn_lvl_q[1];
  assign kb_act  = sync2_q[2] | sync2_q[3];

  always_comb begin
    own_dir = DirNone;
    own_act = 1'b0;
    if (state_q == StBtn) begin
      own_dir = btn_dir;
      own_act = btn_act;
    end else if (state_q == StKb) begin
      own_dir = kb_dir;
      own_act = kb_act;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    wcnt_d      = wcnt_q;
    first_d     = first_q;
    move_up_d   = 1'b0;
    move_down_d = 1'b0;
    wcnt_cur    = wcnt_q;
    first_cur   = first_q;

    unique case (state_q)
      StIdle: begin
        // A tick in the grant cycle never strobes; pacing starts fresh in the owned state.
        wcnt_d  = '0;
        first_d = 1'b1;
        if (kb_act && (!btn_act || KB_PRIORITY)) begin
          state_d = StKb;
          dir_d   = kb_dir;
        end else if (btn_act) begin
          state_d = StBtn;
          dir_d   = btn_dir;
        end
      end

      StBtn, StKb: begin
        if (!own_act) begin
          state_d = StIdle;
        end else begin
          // A direction change (including into or out of cancel) restarts pacing, and a tick
          // in the same cycle already sees the restarted pacing.
          if (own_dir != dir_q) begin
            wcnt_cur  = '0;
            first_cur = 1'b1;
          end
          dir_d   = own_dir;
          wcnt_d  = wcnt_cur;
          first_d = first_cur;
          if (frame_tick && (own_dir != DirNone)) begin
            if (wcnt_cur == '0) begin
              move_up_d   = (own_dir == DirUp);
              move_down_d = (own_dir == DirDown);
              wcnt_d      = first_cur ? HoldLoad : RepeatLoad;
              first_d     = 1'b0;
            end else begin
              wcnt_d = wcnt_cur - 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dir_q       <= DirNone;
      wcnt_q      <= '0;
      first_q     <= 1'b1;
      move_up_q   <= 1'b0;
      move_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      wcnt_q      <= wcnt_d;
      first_q     <= first_d;
      move_up_q   <= move_up_d;
      move_down_q <= move_down_d;
    end
  end

  assign move_up   = move_up_q;
  assign move_down = move_down_q;
  assign owner     = state_q;

endmodule
